// File: rtl/note2dds_voice_sched_if.sv
// Bundle of signals between the voice-allocation logic, the shared
// note-to-increment converter and the scheduler.
//   note_in     : per-voice note numbers, voice i in [7i+6:7i]
//   note_we     : per-voice one-cycle write strobes
//   conv_note   : note presented to the shared converter
//   conv_adder  : converter result (phase increment)
//   adder_out   : per-voice phase increments, voice i in [32i+31:32i]
//   adder_valid : per-voice flag, increment matches latest written note
//   busy        : any conversion pending or in flight
// Modport slave is the scheduler; master is its environment.
interface note2dds_voice_sched_if #(
    parameter int VOICES = 4
);
    logic [7*VOICES-1:0]  note_in;
    logic [VOICES-1:0]    note_we;
    logic [6:0]           conv_note;
    logic [31:0]          conv_adder;
    logic [32*VOICES-1:0] adder_out;
    logic [VOICES-1:0]    adder_valid;
    logic                 busy;

    modport master (
        output note_in, note_we, conv_adder,
        input  conv_note, adder_out, adder_valid, busy
    );

    modport slave (
        input  note_in, note_we, conv_adder,
        output conv_note, adder_out, adder_valid, busy
    );
endinterface

// File: rtl/note2dds_voice_sched.sv
// Round-robin scheduler sharing one note-to-DDS-increment converter among
// VOICES voices. Written notes become pending; the scheduler issues one
// pending note at a time to the converter, holds conv_note stable for the
// converter latency LAT, then captures the result into the voice's
// increment register.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : note2dds_voice_sched_if slave modport (see interface file)
module note2dds_voice_sched #(
    parameter int VOICES = 4,
    parameter int LAT    = 2
) (
    input logic                   clk,
    input logic                   rst,
    note2dds_voice_sched_if.slave bus
);
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic {SCAN = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [VOICES-1:0][6:0]  note_reg;
    logic [VOICES-1:0][31:0] adder_reg;
    logic [VOICES-1:0]       pending;
    logic [VOICES-1:0]       valid;
    logic [6:0]              conv_note_p0;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        cur;
    logic [IDX_W-1:0]        rr;
    logic [IDX_W-1:0]        sel;
    logic                    any_pend;
    logic                    at_lat;
    logic                    issue;
    logic                    capture;
    logic                    busy_c;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int k);
        int s;
        s = (int'(base) + k) % VOICES;
        return s[IDX_W-1:0];
    endfunction

    assign any_pend = |pending;
    assign at_lat   = (cnt == CNT_W'(LAT));

    // Walk downward so the closest pending voice at or after rr wins.
    always_comb begin
        sel = rr;
        for (int k = VOICES - 1; k >= 0; k--) begin
            if (pending[wrap_idx(rr, k)]) sel = wrap_idx(rr, k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= SCAN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:    if (any_pend) state_nxt = HOLD;
            HOLD:    if (at_lat)   state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
    end

    always_comb begin
        issue   = (state == SCAN) && any_pend;
        capture = (state == HOLD) && at_lat;
        busy_c  = any_pend || (state == HOLD);
    end

    // Issue stage: conv_note only moves here, so it stays put until capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_note_p0 <= '0;
            cnt          <= '0;
            cur          <= '0;
            rr           <= '0;
        end else if (issue) begin
            conv_note_p0 <= note_reg[sel];
            cnt          <= '0;
            cur          <= sel;
            rr           <= wrap_idx(sel, 1);
        end else if ((state == HOLD) && !at_lat) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Per-voice state; a fresh strobe overrides any same-cycle clear or set.
    always_ff @(posedge clk) begin
        if (rst) begin
            note_reg  <= '0;
            adder_reg <= '0;
            pending   <= '0;
            valid     <= '0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (bus.note_we[i]) begin
                    note_reg[i] <= bus.note_in[7*i +: 7];
                    pending[i]  <= 1'b1;
                    valid[i]    <= 1'b0;
                end else begin
                    if (issue && (sel == IDX_W'(i))) pending[i] <= 1'b0;
                    if (capture && (cur == IDX_W'(i))) valid[i] <= ~pending[i];
                end
                // A stale result is still written; valid stays low until re-serviced.
                if (capture && (cur == IDX_W'(i))) adder_reg[i] <= bus.conv_adder;
            end
        end
    end

    assign bus.conv_note   = conv_note_p0;
    assign bus.adder_out   = adder_reg;
    assign bus.adder_valid = valid;
    assign bus.busy        = busy_c;
endmodule

// File: tb/tb_note2dds_voice_sched.sv
// Self-checking bench for note2dds_voice_sched with a behavioural
// LAT-stage converter model and a capture scoreboard.
module tb_note2dds_voice_sched;
    localparam int VOICES = 4;
    localparam int LAT    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    note2dds_voice_sched_if #(.VOICES(VOICES)) bus ();

    note2dds_voice_sched #(.VOICES(VOICES), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Converter model: top-octave increment table, LAT register stages,
    // final octave shift combinational on the current note.
    function automatic logic [31:0] base_inc(input int k);
        case (k)
            0:       return 32'd359575;
            1:       return 32'd380957;
            2:       return 32'd403610;
            3:       return 32'd427610;
            4:       return 32'd453037;
            5:       return 32'd479976;
            6:       return 32'd508516;
            7:       return 32'd538754;
            8:       return 32'd570790;
            9:       return 32'd604731;
            10:      return 32'd640684;
            default: return 32'd678780;
        endcase
    endfunction

    function automatic logic [31:0] conv_ref(input logic [6:0] n);
        return base_inc(int'(n) % 12) >> (10 - int'(n) / 12);
    endfunction

    logic [31:0] cv_pipe [LAT];
    always @(posedge clk) begin
        cv_pipe[0] <= base_inc(int'(bus.conv_note) % 12);
        for (int j = 1; j < LAT; j++) cv_pipe[j] <= cv_pipe[j-1];
    end
    assign bus.conv_adder = cv_pipe[LAT-1] >> (10 - int'(bus.conv_note) / 12);

    // Checking
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Scoreboard: expected captures in service order
    typedef struct {
        int          voice;
        logic [31:0] add;
    } exp_t;

    exp_t              sb [$];
    exp_t              e_mon;
    logic [VOICES-1:0] vld_prev = '0;

    task automatic expect_cap(input int v, input logic [6:0] n);
        exp_t e;
        e.voice = v;
        e.add   = conv_ref(n);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < VOICES; i++) begin
            if (bus.adder_valid[i] && !vld_prev[i]) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_capture", sb.size(), 1);
                end else begin
                    e_mon = sb.pop_front();
                    chk("sb_voice", i, e_mon.voice);
                    chk("sb_adder", bus.adder_out[32*i +: 32], e_mon.add);
                end
            end
        end
        vld_prev = bus.adder_valid;
    end

    function automatic logic [31:0] adder_of(input int v);
        return bus.adder_out[32*v +: 32];
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [VOICES-1:0] mask, input logic [7*VOICES-1:0] notes);
        bus.note_in = notes;
        bus.note_we = mask;
        tick();
        bus.note_we = '0;
    endtask

    int order [4] = '{2, 3, 0, 1};

    initial begin
        rst         = 1'b1;
        bus.note_in = '0;
        bus.note_we = '0;
        tick(3);
        rst = 1'b0;

        // reset state
        chk("rst_conv_note", bus.conv_note, 0);
        chk("rst_valid", bus.adder_valid, 0);
        chk("rst_busy", bus.busy, 0);
        for (int v = 0; v < VOICES; v++) chk("rst_adder", adder_of(v), 0);

        // single note, latency LAT+3
        expect_cap(0, 7'd69);
        strobe(4'b0001, {7'd0, 7'd0, 7'd0, 7'd69});
        tick();
        chk("t1_conv_note", bus.conv_note, 69);
        chk("t1_busy", bus.busy, 1);
        tick(2);
        chk("t1_valid_early", bus.adder_valid[0], 0);
        tick();
        chk("t1_valid", bus.adder_valid[0], 1);
        chk("t1_adder", adder_of(0), 18897);
        chk("t1_busy_done", bus.busy, 0);

        // boundary notes, two voices same cycle
        expect_cap(1, 7'd0);
        expect_cap(2, 7'd127);
        strobe(4'b0110, {7'd0, 7'd127, 7'd0, 7'd0});
        tick(4);
        chk("t2_valid1", bus.adder_valid[1], 1);
        chk("t2_adder1", adder_of(1), 351);
        chk("t2_valid2_early", bus.adder_valid[2], 0);
        chk("t2_busy_mid", bus.busy, 1);
        tick(3);
        chk("t2_valid2_pre", bus.adder_valid[2], 0);
        tick();
        chk("t2_valid2", bus.adder_valid[2], 1);
        chk("t2_adder2", adder_of(2), 538754);
        chk("t2_busy_done", bus.busy, 0);

        // set rr to 2, then all voices at once
        expect_cap(1, 7'd50);
        strobe(4'b0010, {7'd0, 7'd0, 7'd50, 7'd0});
        tick(4);
        chk("t3_pre_valid1", bus.adder_valid[1], 1);
        for (int k = 0; k < 4; k++) expect_cap(order[k], 7'(40 + order[k]));
        strobe(4'b1111, {7'd43, 7'd42, 7'd41, 7'd40});
        for (int t = 1; t <= 16; t++) begin
            tick();
            chk("t3_conv_note", bus.conv_note, 40 + order[(t-1)/4]);
            if (t % 4 == 0) chk("t3_valid", bus.adder_valid[order[(t-1)/4]], 1);
        end
        chk("t3_busy_done", bus.busy, 0);

        // rewrite voice 0 during its own HOLD
        strobe(4'b0001, {7'd0, 7'd0, 7'd0, 7'd60});
        tick();
        expect_cap(0, 7'd72);
        strobe(4'b0001, {7'd0, 7'd0, 7'd0, 7'd72});
        tick(2);
        chk("t4_stale_valid", bus.adder_valid[0], 0);
        chk("t4_stale_adder", adder_of(0), conv_ref(7'd60));
        tick();
        chk("t4_reissue_note", bus.conv_note, 72);
        chk("t4_busy", bus.busy, 1);
        tick(3);
        chk("t4_valid", bus.adder_valid[0], 1);
        chk("t4_adder", adder_of(0), 22473);

        // reset in HOLD with cnt=1
        strobe(4'b1000, {7'd100, 7'd0, 7'd0, 7'd0});
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_conv_note", bus.conv_note, 0);
        chk("t5_valid", bus.adder_valid, 0);
        chk("t5_busy", bus.busy, 0);
        for (int v = 0; v < VOICES; v++) chk("t5_adder", adder_of(v), 0);
        tick(5);
        chk("t5_no_wb_valid", bus.adder_valid, 0);
        for (int v = 0; v < VOICES; v++) chk("t5_no_wb_adder", adder_of(v), 0);
        expect_cap(3, 7'd100);
        strobe(4'b1000, {7'd100, 7'd0, 7'd0, 7'd0});
        tick(3);
        chk("t5_fresh_valid_early", bus.adder_valid[3], 0);
        tick();
        chk("t5_fresh_valid", bus.adder_valid[3], 1);
        chk("t5_fresh_adder", adder_of(3), 113259);

        // idle hold
        tick(50);
        chk("t6_conv_note", bus.conv_note, 100);
        chk("t6_valid", bus.adder_valid, 4'b1000);
        chk("t6_busy", bus.busy, 0);
        for (int v = 0; v < 3; v++) chk("t6_adder", adder_of(v), 0);
        chk("t6_adder3", adder_of(3), 113259);

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/note2dds_voice_sched.md
# note2dds_voice_sched

Round-robin scheduler that shares a single note-to-DDS-increment converter among VOICES synth voices. Each voice posts a new MIDI note number. The scheduler serialises the conversions through the shared converter, holds the converter's note input stable for the converter's pipeline latency, and captures each result into a per-voice increment register. It sits between the MIDI/voice-allocation logic and the per-voice DDS phase accumulators.

## Interface
Parameters:
- VOICES, 4: number of voices sharing the converter (2..16).
- LAT, 2: converter latency in register stages, from note input to valid adder output.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- note_in  in  7*VOICES  per-voice note number; voice i in bits [7i+6:7i].
- note_we  in  VOICES  per-voice write strobe, one cycle; latches note_in slice i.
- conv_note  out  7  registered note driven to the shared converter.
- conv_adder  in  32  converter result (phase increment).
- adder_out  out  32*VOICES  per-voice phase increment; voice i in bits [32i+31:32i].
- adder_valid  out  VOICES  adder_out slice i matches the latest written note of voice i.
- busy  out  1  high while any conversion is pending or in flight.

## Operation
- Per-voice state: note_reg[i] (7 b), pending[i], adder_reg[i] (32 b), valid[i].
- note_we[i]: note_reg[i] <= note slice i; pending[i] <= 1; valid[i] <= 0. A strobe always wins over a same-cycle clear of pending or set of valid.
- FSM states: SCAN, HOLD.
- SCAN: when no voice is pending, stay in SCAN. Otherwise sel = first pending index searching upward from rr, wrapping modulo VOICES. Then: conv_note <= note_reg[sel]; cur <= sel; pending[sel] <= 0 (unless note_we[sel] in the same cycle); cnt <= 0; rr <= (sel+1) mod VOICES; go to HOLD.
- HOLD: cnt increments each cycle. On the edge where cnt == LAT: adder_reg[cur] <= conv_adder; valid[cur] <= ~pending[cur] & ~note_we[cur]; go to SCAN.
- A note rewritten during its own conversion: the stale result is still written to adder_reg, valid stays 0, and the voice is re-serviced later.
- conv_note changes only on issue edges. It holds its value through HOLD and after return to SCAN until the next issue.
- busy = (|pending) | (state == HOLD).
- Fairness: a voice that is pending waits for at most VOICES-1 other conversions.

## Timing
- Reset: state SCAN; conv_note, cnt, cur, and rr = 0; all pending, valid, adder_out, and busy = 0.
- Issue at edge E0. conv_note is valid after E0. Capture happens at edge E0+LAT+1 (E3 when LAT=2). adder_valid rises after the capture edge.
- Back-to-back throughput: one conversion per LAT+2 cycles (4 at default). The capture edge returns to SCAN and the next issue occurs one edge later.
- Latency from note_we to adder_valid with an idle scheduler: LAT+3 edges (note_reg at W, issue at W+1, capture at W+LAT+2).
- Same-cycle note_we on several voices: all become pending, serviced in round-robin order starting at rr.
- rst mid-HOLD: conversion abandoned, no writeback, everything returns to reset values.
- The converter is assumed combinationally dependent on note for its final shift, so conv_note must not change before capture. Implementation must guarantee this.

## Test plan
- Reset, then note_we[0] with note 69 -> conv_note=69 one edge after the strobe. adder_out[0]=18897 (604731>>5) and adder_valid[0]=1 exactly LAT+3 edges after the strobe.
- Boundaries: note 0 on voice 1 and note 127 on voice 2 in the same cycle -> voice 1 serviced first, adder_out[1]=351 and adder_out[2]=538754. Captures are 4 cycles apart and busy drops after the second capture.
- All 4 voices strobed together with rr=2 (pre-set by servicing voice 1) -> service order 2, 3, 0, 1. Each is 4 cycles apart and conv_note is stable during every HOLD.
- Rewrite voice 0 (60 then 72) during its HOLD -> first capture leaves adder_valid[0]=0. Re-issue with 72 yields 359575>>4=22473, then valid=1.
- Assert rst for one cycle in HOLD with cnt=1 -> all outputs 0 next cycle and no later writeback. A fresh note_we converts normally.
- Idle hold: no strobes for 50 cycles -> conv_note, adder_out and adder_valid are unchanged and busy=0.
